rr_arb8: RTL and testbench
==========================

# rr_arb8

Eight-way round-robin arbiter that shares the 8-input encode/display path among eight requesters. It keeps one owner at a time and holds the grant while the owner keeps requesting, up to a bounded tenure. It publishes the owner as a 4-bit `{valid, index}` code in the same format the 7-segment decoder consumes, so the display always shows the current owner. It replaces the fixed highest-bit-wins selection with a fair, stateful scheduler.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive cycles one owner keeps the grant while others wait; legal range 2..255.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `en`  input  1  arbiter enable; low forces idle synchronously.
- `req`  input  8  level requests; bit i belongs to requester i.
- `gnt`  output  8  one-hot grant, registered; all zero when idle.
- `l`  output  4  `{gnt_vld, gnt_idx[2:0]}`, registered; feeds the 7-segment decoder.
- `gnt_total`  output  8  count of grants issued, wraps 255→0.

## Operation
- State: FSM {IDLE, GRANT}, `owner[2:0]`, `ptr[2:0]` (search start), `hold_cnt[7:0]`, `gnt_total[7:0]`.
- **Round-robin pick:** search `req` from `ptr` upward, wrapping 7→0. The first set bit wins.
- **Grant side effects:** every new grant sets `ptr = winner+1 mod 8`, clears `hold_cnt` to 0 and increments `gnt_total`.
- **IDLE:**
  - If `en` and `|req`: pick a winner, go to GRANT. `gnt` and `l` update at the same edge.
  - Otherwise stay in IDLE.
- **GRANT:** each edge, evaluate in priority order:
  1. `en`=0 → IDLE.
  2. `req[owner]`=0 (release):
     - Other requests pending → pick the next winner at the same edge (back-to-back, no idle bubble).
     - No other requests → IDLE.
  3. `req[owner]`=1, `hold_cnt`==HOLD_MAX-1, and another request pending (timeout) → pick the next winner from `ptr`. The current owner is excluded this edge.
  4. Otherwise hold. `hold_cnt` increments, saturating at HOLD_MAX-1, so a lone owner holds indefinitely.
- **Outputs:**
  - `gnt` = one-hot(owner) in GRANT, else 0.
  - `l` = {1, owner} in GRANT, else 4'b0000.
- **Disable (`en`=0):** `gnt`/`l` clear at the next edge. `ptr` and `gnt_total` are retained. Requests are ignored while `en`=0.
- **Reset (`rst_n`=0 at an edge):** overrides everything, including mid-grant. State goes to IDLE with `owner`=0, `ptr`=0, `hold_cnt`=0, `gnt`=0, `l`=0, `gnt_total`=0.

## Timing
- All outputs are registered; there is no combinational path from `req`/`en` to any output.
- **Request-to-grant latency:** `req` high before edge k in IDLE → `gnt` valid after edge k (1 cycle).
- **Release-to-handoff:** owner drops `req` before edge k → new `gnt` after edge k. The grant never goes all-zero between owners when others are waiting.
- **Tenure:** an owner with competition keeps the grant for exactly HOLD_MAX cycles, then hands off.
- **Simultaneous release and timeout:** treated as a release.
- **`gnt_total`:** increments on the same edge the new grant appears, including wrap from 255 to 0.
- **Reset pulse:** a single-cycle `rst_n`=0 suffices; arbitration resumes at the first edge with `rst_n`=1.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `req`=8'hFF → `gnt`=0, `l`=0, `gnt_total`=0. Release `rst_n` with `en`=1 → next edge `gnt`=8'h01, `l`=4'b1000.
- **Fair rotation:** `req`=8'b1000_0101, each owner drops its request for one cycle after 3 cycles of grant → owners 0, 2, 7, 0, 2, … ; `gnt_total` increments on each handoff.
- **Timeout:** HOLD_MAX=4, `req`=8'b0000_0011 held constant → owner 0 for 4 cycles, then owner 1 for 4, then owner 0; `l` alternates 8 and 9.
- **Lone owner:** `req`=8'h10 held for 300 cycles → `gnt`=8'h10 throughout, `hold_cnt` saturates, `gnt_total`=1.
- **Disable/reset mid-grant:**
  - `en`=0 during owner 3's grant → `gnt`=0 at the next edge. Re-enable with `req`=8'h18 → owner 4 (from `ptr`=4).
  - `rst_n`=0 mid-grant → all outputs zero at the next edge.
- **Counter wrap:** force 256 grants → `gnt_total` returns to 0.

Source files
------------

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with bounded tenure.
// Publishes the owner as {valid, index} for the 7-segment path.
module rr_arb8 #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [3:0] l,
    output logic [7:0] gnt_total
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_owner;
    logic [2:0] w_owner_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [7:0] r_hold;
    logic [7:0] w_hold_nxt;
    logic [7:0] r_total;
    logic [7:0] r_gnt;
    logic [3:0] r_l;
    logic [7:0] w_others;
    logic [2:0] w_win_all;
    logic [2:0] w_win_oth;
    logic       w_grant;
    logic [2:0] w_win;
    logic [7:0] w_gnt_nxt;
    logic [3:0] w_l_nxt;

    // First set bit of r, searching upward from start with wrap.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] r,
        input logic [2:0] start
    );
        logic [2:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign w_others  = req & ~(8'b1 << r_owner);
    assign w_win_all = rr_pick(req, r_ptr);
    assign w_win_oth = rr_pick(w_others, r_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_grant     = 1'b0;
        w_win       = w_win_all;
        unique case (r_state)
            S_IDLE: begin
                if (en && |req) begin
                    w_grant = 1'b1;
                end
            end
            S_GRANT: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                end else if (!req[r_owner]) begin
                    if (|req) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_hold == HOLD_LAST && |w_others) begin
                    w_grant = 1'b1;
                    w_win   = w_win_oth;
                end else if (r_hold != HOLD_LAST) begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_grant) begin
            w_state_nxt = S_GRANT;
            w_owner_nxt = w_win;
            w_ptr_nxt   = w_win + 3'd1;
            w_hold_nxt  = 8'd0;
        end
    end

    assign w_gnt_nxt = (w_state_nxt == S_GRANT) ? (8'b1 << w_owner_nxt) : 8'h00;
    assign w_l_nxt   = (w_state_nxt == S_GRANT) ? {1'b1, w_owner_nxt} : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= 3'd0;
            r_ptr   <= 3'd0;
            r_hold  <= 8'd0;
            r_total <= 8'd0;
            r_gnt   <= 8'h00;
            r_l     <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_gnt   <= w_gnt_nxt;
            r_l     <= w_l_nxt;
            if (w_grant) begin
                r_total <= r_total + 8'd1;
            end
        end
    end

    assign gnt       = r_gnt;
    assign l         = r_l;
    assign gnt_total = r_total;

endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: behavioural model compared every cycle,
// plus literal checks for reset, timeout, rotation, disable and wrap.
module tb_rr_arb8;

    localparam int HM = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [3:0] l;
    logic [7:0] gnt_total;

    int n_chk;
    int n_err;

    int m_own;
    int m_ten;
    int m_ptr;
    int m_tot;

    rr_arb8 #(.HOLD_MAX(HM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .gnt      (gnt),
        .l        (l),
        .gnt_total(gnt_total)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] mask, input int from);
        int c;
        for (int i = 0; i < 8; i++) begin
            c = (from + i) % 8;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    // Model: owner (-1 = none), cycles shown so far, search start, grant count.
    always @(posedge clk) begin : model
        int own, ten, ptr, tot, w;
        logic [7:0] others;
        own = m_own; ten = m_ten; ptr = m_ptr; tot = m_tot;
        w = -1;
        if (!rst_n) begin
            own = -1; ten = 0; ptr = 0; tot = 0;
        end else if (!en) begin
            own = -1;
        end else if (own < 0) begin
            if (req != 0) w = pick(req, ptr);
        end else begin
            others = req & ~(8'h01 << own);
            if (!req[own]) begin
                if (req != 0) w = pick(req, ptr);
                else own = -1;
            end else if (ten >= HM && others != 0) begin
                w = pick(others, ptr);
            end else begin
                ten = ten + 1;
            end
        end
        if (w >= 0) begin
            own = w;
            ptr = (w + 1) % 8;
            ten = 1;
            tot = (tot + 1) % 256;
        end
        m_own <= own; m_ten <= ten; m_ptr <= ptr; m_tot <= tot;
    end

    always @(negedge clk) begin
        logic [7:0] eg;
        logic [3:0] el;
        eg = (m_own < 0) ? 8'h00 : (8'h01 << m_own);
        el = (m_own < 0) ? 4'h0 : {1'b1, 3'(m_own)};
        chk("model_gnt", 32'(gnt), 32'(eg));
        chk("model_l", 32'(l), 32'(el));
        chk("model_total", 32'(gnt_total), 32'(m_tot));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    initial begin : stim
        logic [3:0] to_seq [9];
        int rot [6];
        n_chk = 0; n_err = 0;
        m_own = -1; m_ten = 0; m_ptr = 0; m_tot = 0;
        to_seq = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h9, 4'h9, 4'h9, 4'h9, 4'h8};
        rot = '{0, 2, 7, 0, 2, 7};
        rst_n = 1'b0; en = 1'b1; req = 8'hFF;

        // reset with all requests high
        cyc(2);
        chk("rst_gnt", 32'(gnt), 32'h00);
        chk("rst_l", 32'(l), 32'h0);
        chk("rst_total", 32'(gnt_total), 32'h0);
        rst_n = 1'b1;
        cyc(1);
        chk("first_gnt", 32'(gnt), 32'h01);
        chk("first_l", 32'(l), 32'h8);

        // tenure timeout between two constant requesters
        req = 8'h03;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            chk("timeout_l", 32'(l), 32'(to_seq[i]));
        end

        // fair rotation with releases
        req = 8'h85;
        do_reset();
        cyc(1);
        for (int k = 0; k < 6; k++) begin
            chk("rot_gnt", 32'(gnt), 32'(8'h01 << rot[k]));
            chk("rot_total", 32'(gnt_total), 32'(k + 1));
            cyc(2);
            req = 8'h85 & ~(8'h01 << rot[k]);
            cyc(1);
            req = 8'h85;
        end

        // lone owner holds indefinitely
        req = 8'h10;
        do_reset();
        cyc(300);
        chk("lone_gnt", 32'(gnt), 32'h10);
        chk("lone_total", 32'(gnt_total), 32'h1);

        // disable mid-grant, resume from ptr
        req = 8'h08;
        do_reset();
        cyc(2);
        chk("dis_own3", 32'(gnt), 32'h08);
        en = 1'b0;
        cyc(1);
        chk("dis_gnt", 32'(gnt), 32'h00);
        chk("dis_l", 32'(l), 32'h0);
        en = 1'b1;
        req = 8'h18;
        cyc(1);
        chk("reen_gnt", 32'(gnt), 32'h10);
        chk("reen_l", 32'(l), 32'hC);
        chk("reen_total", 32'(gnt_total), 32'h2);

        // reset mid-grant
        rst_n = 1'b0;
        cyc(1);
        chk("rstmid_gnt", 32'(gnt), 32'h00);
        chk("rstmid_l", 32'(l), 32'h0);
        chk("rstmid_total", 32'(gnt_total), 32'h0);
        rst_n = 1'b1;

        // counter wrap: one handoff per cycle
        req = 8'h00;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            req = (i % 2 == 0) ? 8'h01 : 8'h02;
            cyc(1);
        end
        chk("wrap_total", 32'(gnt_total), 32'h0);
        chk("wrap_gnt", 32'(gnt), 32'h02);

        // randomized traffic
        req = 8'h00;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            en = ($urandom_range(0, 19) != 0);
            rst_n = ($urandom_range(0, 99) != 0);
            cyc(1);
        end
        rst_n = 1'b1;
        en = 1'b1;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
